iomem_mem_timer_bridge: RTL and testbench
=========================================

Name: iomem_mem_timer_bridge

Overview:
- Parametrised iomem bus responder sitting between `user_processor` iomem port and main memory plus a memory-mapped timer.
- Replaces the fixed 16-deep RAM ready shift chain with an explicit FSM and configurable RAM latency.
- Adds a writable 64-bit timer with prescaler, a 64-bit compare register and a level timer interrupt.
- Decodes RAM, timer and unmapped regions; every access completes with a single registered `iomem_ready_o` pulse.

Parameters:
- RAM_BASE, 32'h4000_0000, RAM region base
- RAM_MASK, 32'h000F_FFFF, RAM region mask; hit when (addr & ~RAM_MASK) == RAM_BASE
- RAM_DEPTH, 'h5000, RAM depth in 32-bit words
- RAM_LATENCY, 2, cycles from RAM strobe to valid `mem_rdata_i`; legal range 1..15
- TIMER_BASE, 32'h3000_0000, timer block base; 16-byte window
- TIMER_DIV, 1, `mtime` increments once every TIMER_DIV clocks; must be ≥1

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  synchronous, active-high reset
- iomem_valid_i  in  1  request valid
- iomem_ready_o  out  1  one-cycle completion pulse
- iomem_wstrb_i  in  4  byte write strobes; 0 means read
- iomem_addr_i  in  32  byte address
- iomem_wdata_i  in  32  write data
- iomem_rdata_o  out  32  read data, valid while `iomem_ready_o` is high
- mem_addr_o  out  $clog2(RAM_DEPTH)  word address, equal to `iomem_addr_i[$clog2(RAM_DEPTH*4)-1:2]`
- mem_wdata_o  out  32  pass-through of `iomem_wdata_i`
- mem_wstrb_o  out  4  RAM byte write enables, one-cycle pulse
- mem_rd_en_o  out  1  RAM read enable, one-cycle pulse
- mem_rdata_i  in  32  RAM read data
- timer_irq_o  out  1  registered; high while mtime ≥ mtimecmp

Behaviour:
- Reset values (synchronous, `rst_i` high):
  - state=IDLE; `iomem_ready_o`=0, `iomem_rdata_o`=0, `mem_wstrb_o`=0, `mem_rd_en_o`=0
  - mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, `timer_irq_o`=0
- FSM states: IDLE, WAIT, RESP.
- IDLE with `iomem_valid_i`=1, RAM hit:
  - Combinationally pulse `mem_wstrb_o`=`iomem_wstrb_i`, or `mem_rd_en_o`=1 when wstrb==0.
  - Load latency counter with RAM_LATENCY; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At counter==1, register `mem_rdata_i` into the rdata register and go to RESP.
- RESP:
  - `iomem_ready_o`=1 for exactly one cycle; go to IDLE.
  - New requests are accepted in IDLE on the following cycle (back-to-back allowed).
- RAM latency: with the request first seen at cycle 0, `iomem_ready_o` is high in cycle RAM_LATENCY+1. RAM strobes never repeat for one request.
- Timer hit in IDLE: perform the register read or write, go directly to RESP (ready in cycle 1).
- Timer register map, offsets from TIMER_BASE:
  - 0x0: mtime[31:0]
  - 0x4: mtime[63:32]
  - 0x8: mtimecmp[31:0]
  - 0xC: mtimecmp[63:32]
  - Byte strobes are honoured.
- Unmapped address in IDLE: go to RESP, rdata=0, no side effects.
- Writes return rdata=0.
- mtime update:
  - Prescaler counts 0..TIMER_DIV-1; mtime increments on wrap.
  - 64-bit wrap to 0 is silent.
  - A bus write to an mtime word in the same cycle as an increment takes priority; the write value is stored unincremented.
- Interrupt: `timer_irq_o` is registered from the unsigned compare mtime ≥ mtimecmp (one-cycle lag) and stays high until mtimecmp is raised or mtime is rewritten.
- Reset asserted mid-access:
  - FSM returns to IDLE and no ready is issued.
  - A pending RAM read is discarded.

Optional Feature:
- `IOMEM_BUS_ERR_EN` defined:
  - Unmapped accesses return rdata=32'hDEAD_BEEF.
  - Sticky status bit at TIMER_BASE+0x10 bit0 is set; any write to that offset clears it.
  - Output `bus_err_o` (1 bit) mirrors the bit.
- Macro undefined: unmapped accesses return 0, no status register, no `bus_err_o` port.

Decomposition:
- Package `iomem_bridge_pkg`:
  - FSM state enum
  - timer register offset localparams (0x0, 0x4, 0x8, 0xC, 0x10)
  - DEAD_BEEF constant
  - region-hit function
- Sub-module `iomem_timer64`: mtime, prescaler, mtimecmp, compare, byte-strobed register writes, read mux. The bridge FSM and decode stay in the top.

Test Plan:
- RAM_LATENCY=2, read 0x4000_0010 with model returning 32'hCAFE_0001 → `mem_rd_en_o` pulses cycle 0 only; ready in cycle 3; rdata=32'hCAFE_0001.
- Write 0x4000_0020, wstrb=4'b0011, wdata=32'h1234_5678 → `mem_wstrb_o`=4'b0011 one cycle; ready in cycle 3; rdata=0. Back-to-back read of the same address returns the lower half updated.
- TIMER_DIV=4, idle 40 cycles after reset, read 0x3000_0000 → value 10 (±1 for sampling); ready in cycle 1.
- Write mtimecmp={32'h0, 32'd20} then poll → `timer_irq_o` rises one cycle after mtime reaches 20; writing mtimecmp_hi=1 drops it the next cycle.
- Read 0x1000_0000 → ready cycle 1; rdata=0, or 32'hDEAD_BEEF with `bus_err_o`=1 under `IOMEM_BUS_ERR_EN`.
- Assert `rst_i` in WAIT of a RAM read → no ready pulse; `mem_*` strobes 0; the next request after reset completes normally.

Source files
------------

// File: rtl/iomem_bridge_pkg.sv
// Shared types, timer register offsets and decode helpers for the iomem
// memory/timer bridge.
package iomem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bridge_state_e;

  localparam logic [4:0] TMR_OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] TMR_OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] TMR_OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] TMR_OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] TMR_OFF_STATUS      = 5'h10;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return ((addr & ~mask) == base);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/iomem_timer64.sv
// 64-bit mtime/mtimecmp timer with prescaler, byte-strobed register writes,
// combinational read mux and a registered level interrupt.
module iomem_timer64
  import iomem_bridge_pkg::*;
#(
  parameter int TIMER_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [1:0]  i_sel,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          r_irq;

  logic          w_tick;
  logic [4:0]    w_off;
  logic          w_wr_time;
  logic          w_wr_cmp;
  logic [63:0]   w_mtime_wr;
  logic [63:0]   w_cmp_wr;

  assign w_off  = {1'b0, i_sel, 2'b00};
  assign w_tick = (r_presc == PW'(TIMER_DIV - 1));

  // Register decode: merged write values and read mux
  always_comb begin
    w_wr_time  = 1'b0;
    w_wr_cmp   = 1'b0;
    w_mtime_wr = r_mtime;
    w_cmp_wr   = r_mtimecmp;
    o_rdata    = 32'h0000_0000;
    case (w_off)
      TMR_OFF_MTIME_LO: begin
        w_wr_time  = i_we;
        w_mtime_wr = {r_mtime[63:32], merge_bytes(r_mtime[31:0], i_wdata, i_wstrb)};
        o_rdata    = r_mtime[31:0];
      end
      TMR_OFF_MTIME_HI: begin
        w_wr_time  = i_we;
        w_mtime_wr = {merge_bytes(r_mtime[63:32], i_wdata, i_wstrb), r_mtime[31:0]};
        o_rdata    = r_mtime[63:32];
      end
      TMR_OFF_MTIMECMP_LO: begin
        w_wr_cmp = i_we;
        w_cmp_wr = {r_mtimecmp[63:32], merge_bytes(r_mtimecmp[31:0], i_wdata, i_wstrb)};
        o_rdata  = r_mtimecmp[31:0];
      end
      TMR_OFF_MTIMECMP_HI: begin
        w_wr_cmp = i_we;
        w_cmp_wr = {merge_bytes(r_mtimecmp[63:32], i_wdata, i_wstrb), r_mtimecmp[31:0]};
        o_rdata  = r_mtimecmp[63:32];
      end
      default: begin
        o_rdata = 32'h0000_0000;
      end
    endcase
  end

  // Prescaler, mtime (bus write beats increment), compare register, irq
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc    <= '0;
      r_mtime    <= 64'h0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_irq      <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_wr_time) begin
        r_mtime <= w_mtime_wr;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end else begin
        r_mtime <= r_mtime;
      end
      if (w_wr_cmp) begin
        r_mtimecmp <= w_cmp_wr;
      end else begin
        r_mtimecmp <= r_mtimecmp;
      end
      r_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  assign o_irq = r_irq;

endmodule

// File: rtl/iomem_mem_timer_bridge.sv
// iomem responder decoding RAM, timer and unmapped regions with a single
// registered ready pulse per access. Optional bus error status: IOMEM_BUS_ERR_EN.
module iomem_mem_timer_bridge
  import iomem_bridge_pkg::*;
#(
  parameter logic [31:0] RAM_BASE    = 32'h4000_0000,
  parameter logic [31:0] RAM_MASK    = 32'h000F_FFFF,
  parameter int          RAM_DEPTH   = 'h5000,
  parameter int          RAM_LATENCY = 2,
  parameter logic [31:0] TIMER_BASE  = 32'h3000_0000,
  parameter int          TIMER_DIV   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         iomem_valid_i,
  output logic                         iomem_ready_o,
  input  logic [3:0]                   iomem_wstrb_i,
  input  logic [31:0]                  iomem_addr_i,
  input  logic [31:0]                  iomem_wdata_i,
  output logic [31:0]                  iomem_rdata_o,
  output logic [$clog2(RAM_DEPTH)-1:0] mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  output logic [3:0]                   mem_wstrb_o,
  output logic                         mem_rd_en_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         timer_irq_o
`ifdef IOMEM_BUS_ERR_EN
  ,
  output logic                         bus_err_o
`endif
);

  localparam int BW = $clog2(RAM_DEPTH * 4);

`ifdef IOMEM_BUS_ERR_EN
  localparam logic [31:0] UNMAPPED_RDATA = DEAD_BEEF;
`else
  localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;
`endif

  bridge_state_e r_state;
  bridge_state_e w_state_nxt;
  logic          r_ready;
  logic [31:0]   r_rdata;
  logic [31:0]   w_rdata_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          r_is_write;
  logic          w_is_write;
  logic          w_ram_hit;
  logic          w_tmr_hit;
  logic          w_tmr_we;
  logic [31:0]   w_tmr_rdata;
  logic [3:0]    w_mem_wstrb;
  logic          w_mem_rd;
`ifdef IOMEM_BUS_ERR_EN
  logic          r_bus_err;
  logic          w_sts_hit;
  logic          w_err_set;
  logic          w_err_clr;

  assign w_sts_hit = region_hit(iomem_addr_i, TIMER_BASE + 32'(TMR_OFF_STATUS), 32'h0000_0003);
  assign bus_err_o = r_bus_err;
`endif

  assign w_is_write = |iomem_wstrb_i;
  assign w_ram_hit  = region_hit(iomem_addr_i, RAM_BASE, RAM_MASK);
  assign w_tmr_hit  = region_hit(iomem_addr_i, TIMER_BASE, 32'h0000_000F);

  iomem_timer64 #(
    .TIMER_DIV (TIMER_DIV)
  ) u_timer (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_we    (w_tmr_we),
    .i_sel   (iomem_addr_i[3:2]),
    .i_wstrb (iomem_wstrb_i),
    .i_wdata (iomem_wdata_i),
    .o_rdata (w_tmr_rdata),
    .o_irq   (timer_irq_o)
  );

  // Bridge FSM: decode, RAM strobes, latency countdown, response data
  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = r_rdata;
    w_cnt_nxt   = r_cnt;
    w_mem_wstrb = 4'b0000;
    w_mem_rd    = 1'b0;
    w_tmr_we    = 1'b0;
`ifdef IOMEM_BUS_ERR_EN
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (iomem_valid_i && !rst_i) begin
          if (w_ram_hit) begin
            if (w_is_write) begin
              w_mem_wstrb = iomem_wstrb_i;
            end else begin
              w_mem_rd = 1'b1;
            end
            w_cnt_nxt   = 4'(RAM_LATENCY);
            w_state_nxt = ST_WAIT;
          end else if (w_tmr_hit) begin
            w_tmr_we    = w_is_write;
            w_rdata_nxt = w_is_write ? 32'h0000_0000 : w_tmr_rdata;
            w_state_nxt = ST_RESP;
`ifdef IOMEM_BUS_ERR_EN
          end else if (w_sts_hit) begin
            w_err_clr   = w_is_write;
            w_rdata_nxt = w_is_write ? 32'h0000_0000 : {31'h0000_0000, r_bus_err};
            w_state_nxt = ST_RESP;
`endif
          end else begin
`ifdef IOMEM_BUS_ERR_EN
            w_err_set   = 1'b1;
`endif
            w_rdata_nxt = w_is_write ? 32'h0000_0000 : UNMAPPED_RDATA;
            w_state_nxt = ST_RESP;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_rdata_nxt = r_is_write ? 32'h0000_0000 : mem_rdata_i;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, ready pulse and response data registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_rdata    <= 32'h0000_0000;
      r_cnt      <= 4'd0;
      r_is_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_RESP);
      r_rdata <= w_rdata_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == ST_IDLE) begin
        r_is_write <= w_is_write;
      end else begin
        r_is_write <= r_is_write;
      end
    end
  end

`ifdef IOMEM_BUS_ERR_EN
  // Sticky unmapped-access flag, cleared by any status write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bus_err <= 1'b0;
    end else if (w_err_set) begin
      r_bus_err <= 1'b1;
    end else if (w_err_clr) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= r_bus_err;
    end
  end
`endif

  assign iomem_ready_o = r_ready;
  assign iomem_rdata_o = r_rdata;
  assign mem_addr_o    = iomem_addr_i[BW-1:2];
  assign mem_wdata_o   = iomem_wdata_i;
  assign mem_wstrb_o   = w_mem_wstrb;
  assign mem_rd_en_o   = w_mem_rd;

endmodule

// File: tb/tb_iomem_mem_timer_bridge.sv
// Directed self-checking bench for iomem_mem_timer_bridge with a fixed-latency
// RAM model (data valid only in the cycle RAM_LATENCY after the read strobe).
module tb_iomem_mem_timer_bridge;

  localparam int LAT   = 2;
  localparam int DIV   = 4;
  localparam int DEPTH = 'h5000;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_i;
  logic          iomem_valid_i;
  logic          iomem_ready_o;
  logic [3:0]    iomem_wstrb_i;
  logic [31:0]   iomem_addr_i;
  logic [31:0]   iomem_wdata_i;
  logic [31:0]   iomem_rdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_wstrb_o;
  logic          mem_rd_en_o;
  logic [31:0]   mem_rdata_i;
  logic          timer_irq_o;
`ifdef IOMEM_BUS_ERR_EN
  logic          bus_err_o;
`endif

  always #5 clk = ~clk;

  iomem_mem_timer_bridge #(
    .RAM_LATENCY (LAT),
    .RAM_DEPTH   (DEPTH),
    .TIMER_DIV   (DIV)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .iomem_valid_i (iomem_valid_i),
    .iomem_ready_o (iomem_ready_o),
    .iomem_wstrb_i (iomem_wstrb_i),
    .iomem_addr_i  (iomem_addr_i),
    .iomem_wdata_i (iomem_wdata_i),
    .iomem_rdata_o (iomem_rdata_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_wstrb_o   (mem_wstrb_o),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_rdata_i   (mem_rdata_i),
    .timer_irq_o   (timer_irq_o)
`ifdef IOMEM_BUS_ERR_EN
    ,
    .bus_err_o     (bus_err_o)
`endif
  );

  // RAM model
  logic [31:0] tb_mem     [0:63];
  logic        tb_written [0:63] = '{default: 1'b0};
  logic [31:0] d1, d2;
  logic        v1 = 1'b0, v2 = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, rdy_cnt = 0, tb_cyc = 0;
  logic [3:0]  last_wstrb = 4'b0000;

  function automatic logic [31:0] seed(input logic [5:0] a);
    case (a)
      6'd4:    return 32'hCAFE_0001;
      6'd8:    return 32'hAAAA_BBBB;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] cur(input logic [5:0] a);
    return tb_written[a] ? tb_mem[a] : seed(a);
  endfunction

  always @(posedge clk) begin
    d1 <= cur(mem_addr_o[5:0]);
    v1 <= mem_rd_en_o;
    d2 <= d1;
    v2 <= v1;
    if (|mem_wstrb_o) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb_o[i]) tb_mem[mem_addr_o[5:0]][8*i +: 8] <= mem_wdata_o[8*i +: 8];
        else tb_mem[mem_addr_o[5:0]][8*i +: 8] <= cur(mem_addr_o[5:0]) >> (8*i);
      end
      tb_written[mem_addr_o[5:0]] <= 1'b1;
      wr_cnt     <= wr_cnt + 1;
      last_wstrb <= mem_wstrb_o;
    end
    if (mem_rd_en_o) rd_cnt <= rd_cnt + 1;
    if (iomem_ready_o) rdy_cnt <= rdy_cnt + 1;
    tb_cyc <= rst_i ? 0 : tb_cyc + 1;
  end

  assign mem_rdata_i = v2 ? d2 : 32'hBAD0_BAD0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bus access; returns data, ready latency (-1 on timeout), start cycle and strobe counts
  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat, output int start,
                          output int n_rd, output int n_wr);
    int rd0, wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    lat = -1;
    rdata = 32'h0;
    @(posedge clk); #1;
    iomem_valid_i = 1'b1;
    iomem_addr_i  = addr;
    iomem_wstrb_i = wstrb;
    iomem_wdata_i = wdata;
    start = tb_cyc;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (iomem_ready_o) begin
        lat   = c;
        rdata = iomem_rdata_o;
        break;
      end
    end
    iomem_valid_i = 1'b0;
    iomem_wstrb_i = 4'b0000;
    n_rd = rd_cnt - rd0;
    n_wr = wr_cnt - wr0;
  endtask

  logic [31:0] rd;
  int lat, st, st2, nr, nw, rdy0, rd0;
  logic seen_strobe;

  initial begin
    rst_i = 1'b1;
    iomem_valid_i = 1'b0;
    iomem_wstrb_i = 4'b0000;
    iomem_addr_i  = 32'h0;
    iomem_wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", iomem_ready_o, 0);
    check_eq("rst_rdata", iomem_rdata_o, 0);
    check_eq("rst_irq", timer_irq_o, 0);
    check_eq("rst_rd_en", mem_rd_en_o, 0);
    check_eq("rst_wstrb", mem_wstrb_o, 0);
    rst_i = 1'b0;
    repeat (40) @(posedge clk);

    // mtime after 41 clocks with divide-by-4 is 10
    bus_xfer(32'h3000_0000, 4'b0000, 32'h0, rd, lat, st, nr, nw);
    check_eq("mtime_lo_val", rd, 10);
    check_eq("mtime_lat", lat, 1);
    check_eq("mtime_no_ram", nr + nw, 0);

    bus_xfer(32'h3000_0008, 4'b1111, 32'd20, rd, lat, st, nr, nw);
    check_eq("cmp_lo_wr_lat", lat, 1);
    check_eq("cmp_lo_wr_rdata", rd, 0);
    bus_xfer(32'h3000_000C, 4'b1111, 32'd0, rd, lat, st, nr, nw);
    check_eq("irq_low_before", timer_irq_o, 0);

    // mtime reaches 20 at clock 80, irq one clock later
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (timer_irq_o) break;
    end
    check_eq("irq_rise_cyc", tb_cyc, 81);

    bus_xfer(32'h3000_000C, 4'b1111, 32'd1, rd, lat, st, nr, nw);
    check_eq("irq_still_high", timer_irq_o, 1);
    @(posedge clk); #1;
    check_eq("irq_dropped", timer_irq_o, 0);
    bus_xfer(32'h3000_000C, 4'b0000, 32'h0, rd, lat, st, nr, nw);
    check_eq("cmp_hi_rd", rd, 1);

    bus_xfer(32'h4000_0010, 4'b0000, 32'h0, rd, lat, st, nr, nw);
    check_eq("ram_rd_data", rd, 32'hCAFE_0001);
    check_eq("ram_rd_lat", lat, LAT + 1);
    check_eq("ram_rd_pulses", nr, 1);
    check_eq("ram_rd_nowr", nw, 0);

    bus_xfer(32'h4000_0020, 4'b0011, 32'h1234_5678, rd, lat, st, nr, nw);
    check_eq("ram_wr_rdata", rd, 0);
    check_eq("ram_wr_lat", lat, LAT + 1);
    check_eq("ram_wr_pulses", nw, 1);
    check_eq("ram_wr_nord", nr, 0);
    check_eq("ram_wr_strb", last_wstrb, 4'b0011);
    bus_xfer(32'h4000_0020, 4'b0000, 32'h0, rd, lat, st, nr, nw);
    check_eq("ram_b2b_data", rd, 32'hAAAA_5678);
    check_eq("ram_b2b_lat", lat, LAT + 1);

    bus_xfer(32'h1000_0000, 4'b0000, 32'h0, rd, lat, st, nr, nw);
    check_eq("unmap_lat", lat, 1);
    check_eq("unmap_no_ram", nr + nw, 0);
`ifdef IOMEM_BUS_ERR_EN
    check_eq("unmap_rdata", rd, 32'hDEAD_BEEF);
    check_eq("bus_err_set", bus_err_o, 1);
    bus_xfer(32'h3000_0010, 4'b0001, 32'h0, rd, lat, st, nr, nw);
    check_eq("bus_err_clr", bus_err_o, 0);
`else
    check_eq("unmap_rdata", rd, 0);
`endif

    // mtime write then read back: ticks land on clocks divisible by 4
    bus_xfer(32'h3000_0000, 4'b1111, 32'h0000_0100, rd, lat, st, nr, nw);
    bus_xfer(32'h3000_0000, 4'b0000, 32'h0, rd, lat, st2, nr, nw);
    check_eq("mtime_wr_rd", rd, 32'h100 + (st2 / 4) - ((st + 1) / 4));
    bus_xfer(32'h3000_0004, 4'b0100, 32'h11AB_2233, rd, lat, st, nr, nw);
    bus_xfer(32'h3000_0004, 4'b0000, 32'h0, rd, lat, st, nr, nw);
    check_eq("mtime_hi_bytes", rd, 32'h00AB_0000);

    // Reset while a RAM read is in its wait state
    @(posedge clk); #1;
    iomem_valid_i = 1'b1;
    iomem_addr_i  = 32'h4000_0010;
    iomem_wstrb_i = 4'b0000;
    @(posedge clk); #1;
    rst_i = 1'b1;
    iomem_valid_i = 1'b0;
    rdy0 = rdy_cnt;
    rd0  = rd_cnt;
    seen_strobe = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) rst_i = 1'b0;
      if (mem_rd_en_o || (|mem_wstrb_o)) seen_strobe = 1'b1;
    end
    check_eq("rst_mid_no_ready", rdy_cnt - rdy0, 0);
    check_eq("rst_mid_no_strobe", seen_strobe, 0);
    check_eq("rst_mid_rd_cnt", rd_cnt - rd0, 0);
    check_eq("rst_mid_rdata", iomem_rdata_o, 0);
    check_eq("rst_mid_irq", timer_irq_o, 0);
    bus_xfer(32'h3000_0008, 4'b0000, 32'h0, rd, lat, st, nr, nw);
    check_eq("rst_cmp_lo", rd, 32'hFFFF_FFFF);
    bus_xfer(32'h4000_0010, 4'b0000, 32'h0, rd, lat, st, nr, nw);
    check_eq("post_rst_data", rd, 32'hCAFE_0001);
    check_eq("post_rst_lat", lat, LAT + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
